// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch: control states, BCD digit
// type, digit limits and the load clamp helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam int BCD_UNITS_MAX = 9;
    localparam int BCD_TENS_MAX  = 5;

    // Out-of-range load digits saturate at the digit's maximum instead of wrapping
    function automatic bcd_t clamp_bcd(input bcd_t value, input bcd_t limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD mod-60 counter (00..59) with clear, clamped parallel load and
// a terminal-count carry that is only high on the enabled 59 -> 00 step.
module bcd_mod60
    import stopwatch_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic load,
    input  bcd_t load_tens,
    input  bcd_t load_units,
    output bcd_t tens,
    output bcd_t units,
    output logic carry
);

    localparam bcd_t UNITS_MAX = bcd_t'(BCD_UNITS_MAX);
    localparam bcd_t TENS_MAX  = bcd_t'(BCD_TENS_MAX);

    assign carry = en && (units == UNITS_MAX) && (tens == TENS_MAX);

    // Priority inside a pair: clear, then load, then count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tens  <= '0;
            units <= '0;
        end else if (clr) begin
            tens  <= '0;
            units <= '0;
        end else if (load) begin
            tens  <= clamp_bcd(load_tens, TENS_MAX);
            units <= clamp_bcd(load_units, UNITS_MAX);
        end else if (en) begin
            if (units == UNITS_MAX) begin
                units <= '0;
                tens  <= (tens == TENS_MAX) ? '0 : tens + bcd_t'(1);
            end else begin
                units <= units + bcd_t'(1);
            end
        end
    end

endmodule

// File: rtl/sec_min_counter.sv
// MM:SS stopwatch: start/stop button FSM (IDLE/RUN/PAUSE), two cascaded BCD
// mod-60 stages and a registered hour carry pulse on the 59:59 -> 00:00 step.
module sec_min_counter
    import stopwatch_pkg::*;
#(
    parameter logic TICK_ACTIVE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       set,
    input  logic       select,
    input  logic [3:0] set_tens,
    input  logic [3:0] set_units,
    output logic [3:0] sec_units,
    output logic [3:0] sec_tens,
    output logic [3:0] min_units,
    output logic [3:0] min_tens,
    output logic       hour_carry,
    output logic       running
);

    sw_state_t state;
    logic      start_q;
    logic      armed;
    logic      press;
    logic      tick_act;
    logic      count_en;
    logic      sec_carry;
    logic      min_carry;

    // armed stays low for the first edge after reset so a held button is not a press
    assign press    = start_stop & ~start_q & armed;
    assign tick_act = (tick == TICK_ACTIVE);
    assign count_en = tick_act & (state == RUN) & ~clear & ~set;

    bcd_mod60 u_sec (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clear),
        .en         (count_en),
        .load       (set & ~select),
        .load_tens  (set_tens),
        .load_units (set_units),
        .tens       (sec_tens),
        .units      (sec_units),
        .carry      (sec_carry)
    );

    bcd_mod60 u_min (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clear),
        .en         (sec_carry),
        .load       (set & select),
        .load_tens  (set_tens),
        .load_units (set_units),
        .tens       (min_tens),
        .units      (min_units),
        .carry      (min_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            running    <= 1'b0;
            start_q    <= 1'b0;
            armed      <= 1'b0;
            hour_carry <= 1'b0;
        end else begin
            start_q    <= start_stop;
            armed      <= 1'b1;
            hour_carry <= min_carry;
            if (clear) begin
                state   <= IDLE;
                running <= 1'b0;
            end else if (press) begin
                unique case (state)
                    IDLE: begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                    RUN: begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                    PAUSE: begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sec_min_counter.sv
// Self-checking bench for sec_min_counter: a table of fixed vectors, directed
// corner sequences and a randomized run checked against a seconds-total model.
module tb_sec_min_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       set = 1'b0;
    logic       select = 1'b0;
    logic [3:0] set_tens = '0;
    logic [3:0] set_units = '0;
    logic [3:0] sec_units;
    logic [3:0] sec_tens;
    logic [3:0] min_units;
    logic [3:0] min_tens;
    logic       hour_carry;
    logic       running;

    int assertCount = 0;
    int failCount = 0;

    // Reference model: elapsed seconds 0..3599 plus the button-controlled mode
    int   mTotal = 0;
    int   mMode = 0;
    logic mPrev = 1'b0;
    logic mArmed = 1'b0;
    logic mCarry = 1'b0;
    logic ssLvl = 1'b0;

    typedef struct {
        logic       rn;
        logic       tk;
        logic       ss;
        logic       clr;
        logic       st;
        logic       sel;
        logic [3:0] tens;
        logic [3:0] units;
        int         expTotal;
        logic       expC;
        logic       expR;
    } vec_t;

    vec_t vecs[12];

    sec_min_counter #(.TICK_ACTIVE(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .start_stop (start_stop),
        .clear      (clear),
        .set        (set),
        .select     (select),
        .set_tens   (set_tens),
        .set_units  (set_units),
        .sec_units  (sec_units),
        .sec_tens   (sec_tens),
        .min_units  (min_units),
        .min_tens   (min_tens),
        .hour_carry (hour_carry),
        .running    (running)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] toDigits(input int total);
        int m;
        int s;
        m = total / 60;
        s = total % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int clampInt(input logic [3:0] v, input int lim);
        return (int'(v) > lim) ? lim : int'(v);
    endfunction

    task automatic modelStep(input logic rn, input logic tk, input logic ss, input logic clr,
                             input logic st, input logic sel, input logic [3:0] tens,
                             input logic [3:0] units);
        logic pressed;
        int   nextMode;
        int   val;
        if (!rn) begin
            mTotal = 0; mMode = 0; mPrev = 1'b0; mArmed = 1'b0; mCarry = 1'b0;
            return;
        end
        pressed  = ss && !mPrev && mArmed;
        nextMode = mMode;
        if (pressed) nextMode = (mMode == 1) ? 2 : 1;
        if (clr) nextMode = 0;
        mCarry = 1'b0;
        if (clr) begin
            mTotal = 0;
        end else if (st) begin
            val = clampInt(tens, 5) * 10 + clampInt(units, 9);
            if (sel) mTotal = val * 60 + (mTotal % 60);
            else     mTotal = (mTotal / 60) * 60 + val;
        end else if (tk && mMode == 1) begin
            if (mTotal == 3599) begin
                mTotal = 0;
                mCarry = 1'b1;
            end else begin
                mTotal = mTotal + 1;
            end
        end
        mPrev = ss; mArmed = 1'b1; mMode = nextMode;
    endtask

    task automatic applyStimulus(input logic rn, input logic tk, input logic ss, input logic clr,
                                 input logic st, input logic sel, input logic [3:0] tens,
                                 input logic [3:0] units);
        rst_n = rn; tick = tk; start_stop = ss; clear = clr;
        set = st; select = sel; set_tens = tens; set_units = units;
        @(posedge clk);
        modelStep(rn, tk, ss, clr, st, sel, tens, units);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] expD, input logic expC,
                               input logic expR);
        logic [15:0] got;
        got = {min_tens, min_units, sec_tens, sec_units};
        assertCount++;
        if (got !== expD) begin
            failCount++;
            $display("[TB] FAIL %s digits: got %h required %h", name, got, expD);
        end
        assertCount++;
        if (hour_carry !== expC) begin
            failCount++;
            $display("[TB] FAIL %s hour_carry: got %b required %b", name, hour_carry, expC);
        end
        assertCount++;
        if (running !== expR) begin
            failCount++;
            $display("[TB] FAIL %s running: got %b required %b", name, running, expR);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, toDigits(mTotal), mCarry, logic'(mMode == 1));
    endtask

    task automatic idleCycle(input string name);
        applyStimulus(1'b1, 1'b0, ssLvl, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        checkModel(name);
    endtask

    task automatic tickCycle(input string name);
        applyStimulus(1'b1, 1'b1, ssLvl, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        checkModel(name);
    endtask

    task automatic pressButton(input string name);
        ssLvl = 1'b1;
        idleCycle(name);
        ssLvl = 1'b0;
        idleCycle(name);
    endtask

    task automatic loadPair(input logic sel, input logic [3:0] tens, input logic [3:0] units);
        applyStimulus(1'b1, 1'b0, ssLvl, 1'b0, 1'b1, sel, tens, units);
        checkModel("load");
    endtask

    task automatic clearCycle();
        applyStimulus(1'b1, 1'b0, ssLvl, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        checkModel("clear");
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0,  0,    1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 4'd12, 59,   1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 4'd9,  3599, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0,  3599, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0,  0,    1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0,  0,    1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0,  1,    1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0,  2,    1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0,  2,    1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0,  2,    1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0,  0,    1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 4'd4,  34,   1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].rn, vecs[i].tk, vecs[i].ss, vecs[i].clr, vecs[i].st,
                          vecs[i].sel, vecs[i].tens, vecs[i].units);
            checkOutput($sformatf("vec%0d", i), toDigits(vecs[i].expTotal), vecs[i].expC,
                        vecs[i].expR);
        end

        // Reset, start, 60 ticks: seconds run 00..59 then roll into one minute
        ssLvl = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        checkOutput("sixty_reset", 16'h0000, 1'b0, 1'b0);
        idleCycle("sixty_release");
        pressButton("sixty_press");
        checkOutput("sixty_running", 16'h0000, 1'b0, 1'b1);
        for (int i = 1; i <= 60; i++) begin
            tickCycle("sixty_tick");
            if (i == 59) checkOutput("sixty_at59", 16'h0059, 1'b0, 1'b1);
            idleCycle("sixty_gap");
        end
        checkOutput("sixty_end", 16'h0100, 1'b0, 1'b1);

        // 59:58 -> 59:59 -> 00:00 with a single-cycle hour carry
        clearCycle();
        loadPair(1'b1, 4'd5, 4'd9);
        loadPair(1'b0, 4'd5, 4'd8);
        pressButton("hour_press");
        tickCycle("hour_tick1");
        checkOutput("hour_5959", 16'h5959, 1'b0, 1'b1);
        tickCycle("hour_tick2");
        checkOutput("hour_wrap", 16'h0000, 1'b1, 1'b1);
        idleCycle("hour_after");
        checkOutput("hour_pulse_end", 16'h0000, 1'b0, 1'b1);

        // Pause freezes digits; a second press resumes
        tickCycle("pause_tick");
        tickCycle("pause_tick");
        pressButton("pause_press");
        checkOutput("paused", 16'h0002, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tickCycle("pause_frozen");
            idleCycle("pause_gap");
        end
        checkOutput("pause_held", 16'h0002, 1'b0, 1'b0);
        pressButton("resume_press");
        checkOutput("resumed", 16'h0002, 1'b0, 1'b1);
        tickCycle("resume_tick");
        checkOutput("resume_count", 16'h0003, 1'b0, 1'b1);

        // Set seconds while running, counting continues from the loaded value
        loadPair(1'b0, 4'd4, 4'd0);
        tickCycle("load_run_tick");
        checkOutput("load_run", 16'h0041, 1'b0, 1'b1);

        // Set and tick together: load wins, tick dropped
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd9);
        checkOutput("set_tick", 16'h0059, 1'b0, 1'b1);

        // Clear with a simultaneous tick at 12:34 while running
        loadPair(1'b1, 4'd1, 4'd2);
        loadPair(1'b0, 4'd3, 4'd4);
        checkOutput("at1234", 16'h1234, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        checkOutput("clear_tick", 16'h0000, 1'b0, 1'b0);
        tickCycle("clear_idle_tick");
        checkOutput("clear_idle", 16'h0000, 1'b0, 1'b0);

        // Reset together with a tick at 59:59, then release with the button held
        loadPair(1'b1, 4'd5, 4'd9);
        loadPair(1'b0, 4'd5, 4'd9);
        pressButton("rst_press");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        checkOutput("rst_tick", 16'h0000, 1'b0, 1'b0);
        ssLvl = 1'b1;
        idleCycle("rst_release_held");
        idleCycle("rst_still_held");
        checkOutput("held_no_press", 16'h0000, 1'b0, 1'b0);
        pressButton("rst_repress");
        checkOutput("rst_repress_run", 16'h0000, 1'b0, 1'b0);
        pressButton("rst_run_press");
        checkOutput("rst_now_run", 16'h0000, 1'b0, 1'b1);

        // Randomized traffic against the model
        ssLvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic rn;
            logic tk;
            logic clr;
            logic st;
            rn  = ($urandom_range(0, 299) != 0);
            tk  = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 149) == 0);
            st  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 5) == 0) ssLvl = ~ssLvl;
            applyStimulus(rn, tk, ssLvl, clr, st, 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            checkModel("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
